// File: rtl/bf16_seq_divider.sv
// BF16 sequential divider: special operands resolve in one edge; normal operands use a
// 10-step restoring divide followed by one round-to-nearest-even step.
// Optional feature macro: BF16_DIV_BY_ZERO_FLAG_EN adds the div_by_zero output.
module bf16_seq_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] num_1,
   input  logic [15:0] num_2,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        zero,
   output logic        underflow,
   output logic        overflow,
   output logic        q_nan,
   output logic        s_nan,
   output logic        positive_inf,
   output logic        negative_inf
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
   ,
   output logic        div_by_zero
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_ROUND  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int F_ZERO = 6;
   localparam int F_UNFL = 5;
   localparam int F_OVFL = 4;
   localparam int F_QNAN = 3;
   localparam int F_SNAN = 2;
   localparam int F_PINF = 1;
   localparam int F_NINF = 0;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [15:0]        result_q, result_d;
   logic [6:0]         flags_q, flags_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [7:0]         divisor_q, divisor_d;
   logic [9:0]         rem_q, rem_d;
   logic [9:0]         quo_q, quo_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [15:0]        stage_res_q, stage_res_d;
   logic [6:0]         stage_flags_q, stage_flags_d;
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
   logic               dbz_q, dbz_d;
   logic               stage_dbz_q, stage_dbz_d;
   logic               spec_dbz_s;
`endif

   logic               op_sign_s;
   logic               zero1_s, zero2_s, inf1_s, inf2_s;
   logic               nan1_s, nan2_s, snan1_s, snan2_s;
   logic               op_special_s;
   logic [15:0]        spec_res_s;
   logic [6:0]         spec_flags_s;
   logic               rem_ge_s;
   logic [7:0]         mant_pre_s;
   logic               guard_s, sticky_s;
   logic [8:0]         mant_sum_s;
   logic [6:0]         mant_fin_s;
   logic signed [9:0]  exp_adj_s, exp_fin_s;
   logic [15:0]        rnd_res_s;
   logic [6:0]         rnd_flags_s;

   // Subnormals (exp = 0) count as zero; exp = FF splits into inf / quiet / signalling NaN.
   assign op_sign_s = num_1[15] ^ num_2[15];
   assign zero1_s   = (num_1[14:7] == 8'h00);
   assign zero2_s   = (num_2[14:7] == 8'h00);
   assign inf1_s    = (num_1[14:7] == 8'hFF) && (num_1[6:0] == 7'h00);
   assign inf2_s    = (num_2[14:7] == 8'hFF) && (num_2[6:0] == 7'h00);
   assign nan1_s    = (num_1[14:7] == 8'hFF) && (num_1[6:0] != 7'h00);
   assign nan2_s    = (num_2[14:7] == 8'hFF) && (num_2[6:0] != 7'h00);
   assign snan1_s   = nan1_s && !num_1[6];
   assign snan2_s   = nan2_s && !num_2[6];
   assign rem_ge_s  = (rem_q >= {2'b00, divisor_q});

   // Special-operand resolution, evaluated on the raw inputs while idle.
   always_comb begin
      spec_res_s   = 16'h0000;
      spec_flags_s = 7'b0000000;
      op_special_s = 1'b1;
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
      spec_dbz_s   = 1'b0;
`endif
      if (snan1_s || snan2_s) begin
         spec_res_s           = 16'h7FC0;
         spec_flags_s[F_SNAN] = 1'b1;
      end else if (nan1_s || nan2_s || (zero1_s && zero2_s) || (inf1_s && inf2_s)) begin
         spec_res_s           = 16'h7FC0;
         spec_flags_s[F_QNAN] = 1'b1;
      end else if (zero2_s || inf1_s) begin
         spec_res_s = {op_sign_s, 8'hFF, 7'h00};
         if (op_sign_s) begin
            spec_flags_s[F_NINF] = 1'b1;
         end else begin
            spec_flags_s[F_PINF] = 1'b1;
         end
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
         spec_dbz_s = !inf1_s;
`endif
      end else if (zero1_s || inf2_s) begin
         spec_res_s           = {op_sign_s, 15'h0000};
         spec_flags_s[F_ZERO] = 1'b1;
      end else begin
         op_special_s = 1'b0;
      end
   end

   // Normalise, round to nearest even, then range-check the final exponent.
   always_comb begin
      if (quo_q[9]) begin
         mant_pre_s = quo_q[9:2];
         guard_s    = quo_q[1];
         sticky_s   = quo_q[0] | (rem_q != 10'd0);
         exp_adj_s  = exp_q;
      end else begin
         mant_pre_s = quo_q[8:1];
         guard_s    = quo_q[0];
         sticky_s   = (rem_q != 10'd0);
         exp_adj_s  = exp_q - 10'sd1;
      end
      mant_sum_s = {1'b0, mant_pre_s} + {8'd0, guard_s & (sticky_s | mant_pre_s[0])};
      if (mant_sum_s[8]) begin
         mant_fin_s = mant_sum_s[7:1];
         exp_fin_s  = exp_adj_s + 10'sd1;
      end else begin
         mant_fin_s = mant_sum_s[6:0];
         exp_fin_s  = exp_adj_s;
      end
      rnd_flags_s = 7'b0000000;
      if (exp_fin_s >= 10'sd255) begin
         rnd_res_s           = {sign_q, 8'hFF, 7'h00};
         rnd_flags_s[F_OVFL] = 1'b1;
         if (sign_q) begin
            rnd_flags_s[F_NINF] = 1'b1;
         end else begin
            rnd_flags_s[F_PINF] = 1'b1;
         end
      end else if (exp_fin_s <= 10'sd0) begin
         rnd_res_s           = {sign_q, 15'h0000};
         rnd_flags_s[F_ZERO] = 1'b1;
         rnd_flags_s[F_UNFL] = 1'b1;
      end else begin
         rnd_res_s = {sign_q, exp_fin_s[7:0], mant_fin_s};
      end
   end

   // FSM next-state and datapath updates.
   always_comb begin
      state_d       = state_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      result_d      = result_q;
      flags_d       = flags_q;
      sign_d        = sign_q;
      exp_d         = exp_q;
      divisor_d     = divisor_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      cnt_d         = cnt_q;
      stage_res_d   = stage_res_q;
      stage_flags_d = stage_flags_q;
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
      dbz_d         = dbz_q;
      stage_dbz_d   = stage_dbz_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d  = 1'b1;
               flags_d = 7'b0000000;
               sign_d  = op_sign_s;
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
               dbz_d       = 1'b0;
               stage_dbz_d = spec_dbz_s;
`endif
               if (op_special_s) begin
                  stage_res_d   = spec_res_s;
                  stage_flags_d = spec_flags_s;
                  state_d       = S_DONE;
               end else begin
                  exp_d     = $signed({2'b00, num_1[14:7]}) - $signed({2'b00, num_2[14:7]}) + 10'sd127;
                  divisor_d = {1'b1, num_2[6:0]};
                  rem_d     = {3'b001, num_1[6:0]};
                  quo_d     = 10'd0;
                  cnt_d     = 4'd0;
                  state_d   = S_DIVIDE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DIVIDE: begin
            rem_d = (rem_ge_s ? (rem_q - {2'b00, divisor_q}) : rem_q) << 1;
            quo_d = {quo_q[8:0], rem_ge_s};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               state_d = S_ROUND;
            end else begin
               state_d = S_DIVIDE;
            end
         end
         S_ROUND: begin
            stage_res_d   = rnd_res_s;
            stage_flags_d = rnd_flags_s;
            state_d       = S_DONE;
         end
         S_DONE: begin
            result_d = stage_res_q;
            flags_d  = stage_flags_q;
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
            dbz_d    = stage_dbz_q;
`endif
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         result_q      <= 16'h0000;
         flags_q       <= 7'b0000000;
         sign_q        <= 1'b0;
         exp_q         <= 10'sd0;
         divisor_q     <= 8'd0;
         rem_q         <= 10'd0;
         quo_q         <= 10'd0;
         cnt_q         <= 4'd0;
         stage_res_q   <= 16'h0000;
         stage_flags_q <= 7'b0000000;
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
         dbz_q         <= 1'b0;
         stage_dbz_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         result_q      <= result_d;
         flags_q       <= flags_d;
         sign_q        <= sign_d;
         exp_q         <= exp_d;
         divisor_q     <= divisor_d;
         rem_q         <= rem_d;
         quo_q         <= quo_d;
         cnt_q         <= cnt_d;
         stage_res_q   <= stage_res_d;
         stage_flags_q <= stage_flags_d;
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
         dbz_q         <= dbz_d;
         stage_dbz_q   <= stage_dbz_d;
`endif
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign result       = result_q;
   assign zero         = flags_q[F_ZERO];
   assign underflow    = flags_q[F_UNFL];
   assign overflow     = flags_q[F_OVFL];
   assign q_nan        = flags_q[F_QNAN];
   assign s_nan        = flags_q[F_SNAN];
   assign positive_inf = flags_q[F_PINF];
   assign negative_inf = flags_q[F_NINF];
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
   assign div_by_zero  = dbz_q;
`endif

endmodule

// File: tb/tb_bf16_seq_divider.sv
// Scoreboard bench for bf16_seq_divider: directed vectors, reset abort, busy re-start,
// then randomized operands checked against an integer-arithmetic BF16 division model.
module tb_bf16_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_1 = 16'h0000;
   logic [15:0] num_2 = 16'h0000;
   logic        busy, done;
   logic [15:0] result;
   logic        zero, underflow, overflow, q_nan, s_nan, positive_inf, negative_inf;
   logic [7:0]  flags_s;
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
   logic        div_by_zero;
   localparam bit DBZ_EN = 1'b1;
   assign flags_s = {div_by_zero, zero, underflow, overflow, q_nan, s_nan, positive_inf, negative_inf};
`else
   localparam bit DBZ_EN = 1'b0;
   assign flags_s = {1'b0, zero, underflow, overflow, q_nan, s_nan, positive_inf, negative_inf};
`endif

   typedef struct {
      logic [15:0] res;
      logic [7:0]  flg;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   errs = 0;
   int   cyc = 0;
   int   n_done = 0;

   bf16_seq_divider dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_1(num_1), .num_2(num_2),
      .busy(busy), .done(done), .result(result),
      .zero(zero), .underflow(underflow), .overflow(overflow),
      .q_nan(q_nan), .s_nan(s_nan), .positive_inf(positive_inf), .negative_inf(negative_inf)
`ifdef BF16_DIV_BY_ZERO_FLAG_EN
      , .div_by_zero(div_by_zero)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done) n_done <= n_done + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] r, input logic [7:0] f, input int l);
      exp_t e;
      e.res = r; e.flg = f; e.acc = 0; e.lat = l;
      return e;
   endfunction

   // Reference: classify operands, then divide exactly with integers and round to nearest even.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      int e1, e2, f1, f2, m1, m2, q, r, sh, mant, low, half, e;
      bit s, z1, z2, i1, i2, n1, n2, sn1, sn2;
      s  = a[15] ^ b[15];
      e1 = int'(a[14:7]); f1 = int'(a[6:0]);
      e2 = int'(b[14:7]); f2 = int'(b[6:0]);
      z1 = (e1 == 0); z2 = (e2 == 0);
      i1 = (e1 == 255) && (f1 == 0); i2 = (e2 == 255) && (f2 == 0);
      n1 = (e1 == 255) && (f1 != 0); n2 = (e2 == 255) && (f2 != 0);
      sn1 = n1 && (f1 < 64); sn2 = n2 && (f2 < 64);
      if (sn1 || sn2) return mk(16'h7FC0, 8'h04, 1);
      if (n1 || n2 || (z1 && z2) || (i1 && i2)) return mk(16'h7FC0, 8'h08, 1);
      if (z2 || i1) return mk({s, 15'h7F80}, {DBZ_EN & !i1, 5'b00000, !s, s}, 1);
      if (z1 || i2) return mk({s, 15'h0000}, 8'h40, 1);
      m1 = 128 + f1; m2 = 128 + f2;
      e  = e1 - e2 + 127;
      q  = (m1 << 20) / m2;
      r  = (m1 << 20) % m2;
      if (q >= (1 << 20)) sh = 13;
      else begin sh = 12; e = e - 1; end
      mant = q >> sh;
      low  = q & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (low > half || (low == half && (r != 0 || (mant % 2) == 1))) mant = mant + 1;
      if (mant == 256) begin mant = 128; e = e + 1; end
      if (e >= 255) return mk({s, 15'h7F80}, {6'b000100, !s, s}, 12);
      if (e <= 0) return mk({s, 15'h0000}, 8'h60, 12);
      return mk({s, 8'(e), 7'(mant - 128)}, 8'h00, 12);
   endfunction

   function automatic logic [15:0] rand_op();
      logic [7:0] e;
      logic [6:0] m;
      m = 7'($urandom);
      case ($urandom_range(0, 9))
         0: e = 8'h00;
         1: e = 8'hFF;
         2: begin e = 8'hFF; m = 7'h00; end
         3: e = 8'(250 + $urandom_range(0, 4));
         4: e = 8'(1 + $urandom_range(0, 4));
         default: e = 8'($urandom_range(1, 254));
      endcase
      return {1'($urandom), e, m};
   endfunction

   // Monitor: pops the scoreboard on each done pulse; checks busy while an op is in flight.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("result", {16'd0, result}, {16'd0, e.res});
               check("flags", {24'd0, flags_s}, {24'd0, e.flg});
               check("latency", cyc - e.acc, e.lat);
               check("busy_at_done", {31'd0, busy}, 32'd0);
            end
         end else if (sb.size() != 0 && cyc >= sb[0].acc) begin
            check("busy_inflight", {31'd0, busy}, 32'd1);
         end
      end
   end

   // Called at a negedge: drive one accepted start and record its expectation.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input exp_t ex);
      exp_t e;
      e = ex;
      e.acc = cyc + 1;
      sb.push_back(e);
      num_1 = a; num_2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      num_1 = 16'($urandom); num_2 = 16'($urandom);
   endtask

   // Wait for the scoreboard to empty; pmode 1/2 re-pulses start (random/always) while busy.
   task automatic drain(input int pmode);
      int acc, lat;
      acc = sb[$].acc; lat = sb[$].lat;
      for (int k = 0; k < 40; k++) begin
         if (sb.size() == 0) return;
         if (pmode != 0 && (cyc + 1 <= acc + lat) && (pmode == 2 || $urandom_range(0, 3) == 0)) begin
            num_1 = 16'($urandom); num_2 = 16'($urandom); start = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
      end
      if (sb.size() != 0) begin
         check("timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      logic [15:0] a, b;
      int base;
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_result", {16'd0, result}, 32'd0);
      check("reset_flags", {24'd0, flags_s}, 32'd0);
      check("reset_busy_done", {30'd0, busy, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(16'h3F80, 16'h4000, mk(16'h3F00, 8'h00, 12));              drain(0);
      issue(16'h3F80, 16'h4040, mk(16'h3EAB, 8'h00, 12));              drain(0);
      issue(16'h4040, 16'h3F80, mk(16'h4040, 8'h00, 12));              drain(0);
      issue(16'hC000, 16'h0000, mk(16'hFF80, {DBZ_EN, 7'h01}, 1));     drain(0);
      issue(16'h7F00, 16'h0080, mk(16'h7F80, 8'h12, 12));              drain(0);
      issue(16'h0080, 16'h7F00, mk(16'h0000, 8'h60, 12));              drain(0);
      issue(16'h7F81, 16'h3F80, mk(16'h7FC0, 8'h04, 1));               drain(0);
      issue(16'h0000, 16'h0000, mk(16'h7FC0, 8'h08, 1));               drain(0);
      issue(16'h3F80, 16'h4040, mk(16'h3EAB, 8'h00, 12));              drain(2);
      issue(16'hC000, 16'h0000, mk(16'hFF80, {DBZ_EN, 7'h01}, 1));     drain(2);

      issue(16'h3F80, 16'h4000, mk(16'h3F00, 8'h00, 12));
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_result", {16'd0, result}, 32'd0);
      check("abort_flags", {24'd0, flags_s}, 32'd0);
      check("abort_busy_done", {30'd0, busy, done}, 32'd0);
      sb.delete();
      base = n_done;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("abort_no_done", n_done - base, 32'd0);
      issue(16'h3F80, 16'h4040, mk(16'h3EAB, 8'h00, 12));              drain(0);

      for (int i = 0; i < 400; i++) begin
         a = rand_op();
         b = rand_op();
         issue(a, b, model(a, b));
         drain(1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, errs);
      $finish;
   end

endmodule
